// File: rtl/sbox_lanes_pipe.sv
// Pipelined AES S-box array: NLANES byte lanes per beat, forward or inverse per beat,
// shared subfield inversion core, valid/ready elastic stages (PIPE = 1..3).
module sbox_lanes_pipe #(
  parameter int unsigned NLANES = 4,
  parameter int unsigned PIPE   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_inv,
  input  logic [8*NLANES-1:0]   in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_inv,
  output logic [8*NLANES-1:0]   out_data,
  output logic [1:0]            in_flight
);
  localparam int unsigned W = 8 * NLANES;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] x;
    acc = '0;
    x   = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return acc;
  endfunction

  function automatic logic [7:0] gf_sq(input logic [7:0] a);
    return gf_mul(a, a);
  endfunction

  function automatic logic [7:0] top_layer(input logic [7:0] u, input logic inv);
    return inv ? ({u[6:0], u[7]} ^ {u[4:0], u[7:5]} ^ {u[1:0], u[7:2]} ^ 8'h05) : u;
  endfunction

  // x^-1 = (x^17)^-1 * x^16: x^17 lies in the GF(2^4) subfield, where its inverse is its
  // 14th power. Returns {subfield inverse, x^16} for the bottom multiplier.
  function automatic logic [15:0] inv_core(input logic [7:0] t);
    logic [7:0] x16, n, n2, n4, n8;
    x16 = gf_sq(gf_sq(gf_sq(gf_sq(t))));
    n   = gf_mul(x16, t);
    n2  = gf_sq(n);
    n4  = gf_sq(n2);
    n8  = gf_sq(n4);
    return {gf_mul(gf_mul(n8, n4), n2), x16};
  endfunction

  function automatic logic [7:0] bottom_layer(input logic [15:0] m, input logic inv);
    logic [7:0] b;
    b = gf_mul(m[15:8], m[7:0]);
    return inv ? b : (b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
                      ^ {b[3:0], b[7:4]} ^ 8'h63);
  endfunction

  logic [PIPE-1:0] valid_q, inv_q, adv, valid_in, inv_in, ld;
  logic [W-1:0]    out_q;

  // A stage advances unless it and every stage after it is full while the output stalls.
  always_comb begin : p_adv
    logic full;
    full = 1'b1;
    adv  = '0;
    for (int k = int'(PIPE) - 1; k >= 0; k--) begin
      full   = full & valid_q[k];
      adv[k] = out_ready | ~full;
    end
  end

  always_comb begin
    valid_in    = '0;
    inv_in      = '0;
    valid_in[0] = in_valid;
    inv_in[0]   = in_inv;
    for (int k = 1; k < int'(PIPE); k++) begin
      valid_in[k] = valid_q[k-1];
      inv_in[k]   = inv_q[k-1];
    end
  end

  assign ld = adv & valid_in;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      inv_q   <= '0;
    end else begin
      for (int k = 0; k < int'(PIPE); k++) begin
        if (adv[k]) valid_q[k] <= valid_in[k];
        if (ld[k])  inv_q[k]   <= inv_in[k];
      end
    end
  end

  always_comb begin
    in_flight = '0;
    for (int k = 0; k < int'(PIPE); k++) in_flight = in_flight + {1'b0, valid_q[k]};
  end

  if (PIPE == 1) begin : g_pipe1
    logic [W-1:0] res;
    always_comb begin
      res = '0;
      for (int l = 0; l < int'(NLANES); l++)
        res[8*l +: 8] = bottom_layer(inv_core(top_layer(in_data[8*l +: 8], in_inv)), in_inv);
    end
    always_ff @(posedge clk) begin
      if (rst)        out_q <= '0;
      else if (ld[0]) out_q <= res;
    end
  end else if (PIPE == 2) begin : g_pipe2
    logic [W-1:0] t_q, res;
    always_ff @(posedge clk) begin
      if (rst) t_q <= '0;
      else if (ld[0]) begin
        for (int l = 0; l < int'(NLANES); l++) t_q[8*l +: 8] <= top_layer(in_data[8*l +: 8], in_inv);
      end
    end
    always_comb begin
      res = '0;
      for (int l = 0; l < int'(NLANES); l++)
        res[8*l +: 8] = bottom_layer(inv_core(t_q[8*l +: 8]), inv_q[0]);
    end
    always_ff @(posedge clk) begin
      if (rst)        out_q <= '0;
      else if (ld[1]) out_q <= res;
    end
  end else begin : g_pipe3
    logic [W-1:0]   t_q, res;
    logic [2*W-1:0] m_q;
    always_ff @(posedge clk) begin
      if (rst) begin
        t_q <= '0;
        m_q <= '0;
      end else begin
        if (ld[0]) begin
          for (int l = 0; l < int'(NLANES); l++)
            t_q[8*l +: 8] <= top_layer(in_data[8*l +: 8], in_inv);
        end
        if (ld[1]) begin
          for (int l = 0; l < int'(NLANES); l++) m_q[16*l +: 16] <= inv_core(t_q[8*l +: 8]);
        end
      end
    end
    always_comb begin
      res = '0;
      for (int l = 0; l < int'(NLANES); l++)
        res[8*l +: 8] = bottom_layer(m_q[16*l +: 16], inv_q[1]);
    end
    always_ff @(posedge clk) begin
      if (rst)        out_q <= '0;
      else if (ld[2]) out_q <= res;
    end
  end

  assign in_ready  = adv[0];
  assign out_valid = valid_q[PIPE-1];
  assign out_inv   = inv_q[PIPE-1];
  assign out_data  = out_q;

endmodule

// File: tb/tb_sbox_lanes_pipe.sv
// Bench for sbox_lanes_pipe: directed vectors, exhaustive round trip, backpressure, reset
// and randomized traffic on several NLANES/PIPE configurations against a table model.
module tb_sbox_lanes_pipe;
  localparam int unsigned NL = 4;
  localparam int unsigned PP = 2;
  localparam int NCFG = 6;
  localparam int unsigned CFG_NL [NCFG] = '{1, 16, 1, 16, 1, 16};
  localparam int unsigned CFG_PP [NCFG] = '{1, 1, 2, 2, 3, 3};
  localparam int GEN_BEATS = 1500;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int ndone  = 0;
  logic [7:0] sbox [256];
  logic [7:0] isbox [256];

  function automatic int gmul(int a, int b);
    int p;
    p = 0;
    for (int i = 0; i < 8; i++) begin
      if (((b >> i) & 1) != 0) p = p ^ a;
      a = a << 1;
      if ((a & 256) != 0) a = a ^ 'h11b;
    end
    return p;
  endfunction

  // FIPS-197 tables from first principles: brute-force inverse then the affine map.
  initial begin : build_tables
    for (int a = 0; a < 256; a++) begin
      int ainv;
      int s;
      ainv = 0;
      for (int b = 1; b < 256; b++) if (gmul(a, b) == 1) ainv = b;
      s = 0;
      for (int i = 0; i < 8; i++) begin
        int bv;
        bv = ((ainv >> i) ^ (ainv >> ((i + 4) % 8)) ^ (ainv >> ((i + 5) % 8))
              ^ (ainv >> ((i + 6) % 8)) ^ (ainv >> ((i + 7) % 8)) ^ ('h63 >> i)) & 1;
        s = s | (bv << i);
      end
      sbox[a]  = s[7:0];
      isbox[s] = a[7:0];
    end
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] ref_beat(input logic [127:0] d, input logic inv, input int nl);
    logic [127:0] r;
    r = '0;
    for (int l = 0; l < nl; l++) r[8*l +: 8] = inv ? isbox[d[8*l +: 8]] : sbox[d[8*l +: 8]];
    return r;
  endfunction

  // ---------------- main DUT: NLANES=4, PIPE=2 ----------------
  logic rst = 1'b1, in_valid = 1'b0, in_inv = 1'b0, out_ready = 1'b0;
  logic in_ready, out_valid, out_inv;
  logic [8*NL-1:0] in_data = '0;
  logic [8*NL-1:0] out_data;
  logic [1:0] in_flight;

  sbox_lanes_pipe #(.NLANES(NL), .PIPE(PP)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_inv(in_inv),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_inv(out_inv),
    .out_data(out_data), .in_flight(in_flight)
  );

  logic [127:0] exp_q[$];
  logic einv_q[$];
  int acc_q[$];
  int cyc = 0;
  int emitted = 0;
  int n_acc = 0;
  bit lat_on = 1'b0;
  bit held = 1'b0;
  logic [127:0] last_out = '0;
  logic last_inv = 1'b0;
  logic [8*NL-1:0] held_data = '0;
  logic held_inv = 1'b0;

  task automatic step(input logic iv, input logic inv, input logic [8*NL-1:0] d, input logic ordy);
    logic [127:0] e;
    logic ei;
    int a;
    @(negedge clk);
    in_valid = iv; in_inv = inv; in_data = d; out_ready = ordy;
    #1;
    cyc++;
    chk("in_flight", 128'(in_flight), 128'(exp_q.size()));
    chk("in_ready", 128'(in_ready), 128'(ordy || exp_q.size() < int'(PP)));
    if (held) begin
      chk("hold_data", 128'(out_data), 128'(held_data));
      chk("hold_inv", 128'(out_inv), 128'(held_inv));
    end
    if (out_valid && exp_q.size() == 0) chk("spurious_out", 128'(out_valid), 128'(0));
    else if (out_valid && ordy) begin
      e = exp_q.pop_front(); ei = einv_q.pop_front(); a = acc_q.pop_front();
      chk("out_data", 128'(out_data), e);
      chk("out_inv", 128'(out_inv), 128'(ei));
      if (lat_on) chk("latency", 128'(cyc - a), 128'(PP));
      last_out = 128'(out_data); last_inv = out_inv; emitted++;
    end
    held = out_valid && !ordy; held_data = out_data; held_inv = out_inv;
    if (iv && in_ready) begin
      exp_q.push_back(ref_beat(128'(d), inv, int'(NL))); einv_q.push_back(inv);
      acc_q.push_back(cyc); n_acc++;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_inv = 1'b0; in_data = '0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_out_data", 128'(out_data), 128'(0));
    chk("rst_out_inv", 128'(out_inv), 128'(0));
    chk("rst_in_flight", 128'(in_flight), 128'(0));
    chk("rst_in_ready", 128'(in_ready), 128'(1));
    exp_q.delete(); einv_q.delete(); acc_q.delete(); held = 1'b0;
  endtask

  initial begin : main_seq
    int e0;
    do_reset();
    lat_on = 1'b1;
    step(1'b1, 1'b0, 32'h0053_0100, 1'b1);
    repeat (PP + 1) step(1'b0, 1'b0, '0, 1'b1);
    chk("fwd_vec", last_out, 128'h63ED_7C63);
    chk("fwd_mode", 128'(last_inv), 128'(0));
    step(1'b1, 1'b1, 32'h63ED_7C63, 1'b1);
    repeat (PP + 1) step(1'b0, 1'b0, '0, 1'b1);
    chk("inv_vec", last_out, 128'h0053_0100);
    chk("inv_mode", 128'(last_inv), 128'(1));

    // every byte in both modes, mode toggling each beat, no bubbles
    e0 = emitted;
    for (int j = 0; j < 128; j++) begin
      logic [8*NL-1:0] d;
      for (int l = 0; l < int'(NL); l++) d[8*l +: 8] = 8'(4 * j + l);
      step(1'b1, 1'((j % 2) ^ (j >= 64 ? 1 : 0)), d, 1'b1);
    end
    repeat (PP + 1) step(1'b0, 1'b0, '0, 1'b1);
    chk("exhaustive_count", 128'(emitted - e0), 128'(128));
    lat_on = 1'b0;

    for (int j = 0; j < 4; j++) step(1'b1, 1'($urandom_range(0, 1)), 32'($urandom), 1'b0);
    chk("bp_full", 128'(in_flight), 128'(PP));
    chk("bp_in_ready", 128'(in_ready), 128'(0));
    for (int j = 0; j < 8; j++) step(1'b0, 1'b0, '0, 1'b1);
    chk("bp_drained", 128'(exp_q.size()), 128'(0));

    e0 = n_acc;
    for (int c = 0; c < 20000 && n_acc - e0 < 3000; c++)
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 32'($urandom),
           1'($urandom_range(0, 1)));
    for (int c = 0; c < 20 && exp_q.size() > 0; c++) step(1'b0, 1'b0, '0, 1'b1);
    chk("rand_drained", 128'(exp_q.size()), 128'(0));

    step(1'b1, 1'b0, 32'($urandom), 1'b0);
    step(1'b1, 1'b1, 32'($urandom), 1'b0);
    step(1'b0, 1'b0, '0, 1'b0);
    chk("pre_rst_flight", 128'(in_flight), 128'(2));
    do_reset();
    for (int j = 0; j < 6; j++) begin
      step(1'b0, 1'b0, '0, 1'b1);
      chk("post_rst_quiet", 128'(out_valid), 128'(0));
    end

    for (int i = 0; i < 40000 && ndone < NCFG; i++) @(negedge clk);
    chk("gen_done", 128'(ndone), 128'(NCFG));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // ---------------- randomized configurations ----------------
  for (genvar g = 0; g < NCFG; g++) begin : g_cfg
    localparam int unsigned GNL = CFG_NL[g];
    localparam int unsigned GPP = CFG_PP[g];
    logic rst_g = 1'b1, iv = 1'b0, ii = 1'b0, ordy = 1'b0;
    logic ir, ov, oi;
    logic [8*GNL-1:0] id = '0;
    logic [8*GNL-1:0] od;
    logic [1:0] fl;
    logic [127:0] gq[$];
    logic giq[$];

    sbox_lanes_pipe #(.NLANES(GNL), .PIPE(GPP)) u_dut (
      .clk(clk), .rst(rst_g), .in_valid(iv), .in_ready(ir), .in_inv(ii), .in_data(id),
      .out_valid(ov), .out_ready(ordy), .out_inv(oi), .out_data(od), .in_flight(fl)
    );

    initial begin : traffic
      int acc;
      logic [127:0] rnd;
      logic hv;
      logic hi;
      logic [8*GNL-1:0] hd;
      acc = 0; hv = 1'b0; hd = '0; hi = 1'b0;
      repeat (2) @(negedge clk);
      rst_g = 1'b0;
      for (int c = 0; c < 15000 && (acc < GEN_BEATS || gq.size() > 0); c++) begin
        @(negedge clk);
        rnd  = {$urandom, $urandom, $urandom, $urandom};
        iv   = (acc < GEN_BEATS) ? 1'($urandom_range(0, 1)) : 1'b0;
        ordy = (acc < GEN_BEATS) ? 1'($urandom_range(0, 1)) : 1'b1;
        ii   = 1'($urandom_range(0, 1));
        id   = rnd[8*GNL-1:0];
        #1;
        chk($sformatf("cfg%0d_in_flight", g), 128'(fl), 128'(gq.size()));
        chk($sformatf("cfg%0d_in_ready", g), 128'(ir), 128'(ordy || gq.size() < int'(GPP)));
        if (hv) begin
          chk($sformatf("cfg%0d_hold_data", g), 128'(od), 128'(hd));
          chk($sformatf("cfg%0d_hold_inv", g), 128'(oi), 128'(hi));
        end
        if (ov && gq.size() == 0) chk($sformatf("cfg%0d_spurious", g), 128'(ov), 128'(0));
        else if (ov && ordy) begin
          chk($sformatf("cfg%0d_data", g), 128'(od), gq.pop_front());
          chk($sformatf("cfg%0d_inv", g), 128'(oi), 128'(giq.pop_front()));
        end
        hv = ov && !ordy; hd = od; hi = oi;
        if (iv && ir) begin
          gq.push_back(ref_beat(128'(id), ii, int'(GNL)));
          giq.push_back(ii);
          acc++;
        end
      end
      chk($sformatf("cfg%0d_drained", g), 128'(gq.size()), 128'(0));
      ndone++;
    end
  end

endmodule
